// File: rtl/instr_fetch_unit_pkg.sv
// fetch_pkg: shared widths, PC increment, FSM states and FIFO entry type for the fetch front end
package fetch_pkg;
    localparam int ADDR_W = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WAIT_DISCARD} fetch_state_t;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/response and decode handshake bundle
interface instr_fetch_unit_if;
    import fetch_pkg::*;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry {pc,instr} buffer with sync push/pop/flush; head reads as zero when empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     resetl,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    assign count = cnt_q;
    assign rdata = cnt_q != '0 ? mem[rd_q] : '0;
    // pointer and occupancy update; flush wins over push/pop
    always_comb begin
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        wr_d  = flush ? '0 : wr_q + AW'(push);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    // pointer/occupancy registers
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    // storage needs no reset: the head is masked while empty
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wr_q] <= wdata;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, single-outstanding imem requests, redirect/squash; FETCH_STATS_EN adds flush/stall counters
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic [ADDR_W-1:0]  startpc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    instr_fetch_unit_if.master bus,
    output logic [63:0]        fetch_stats
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic              discard_q, discard_d;
    logic              push, pop, redir, req_fire;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    assign redir    = redirect && state_q != IDLE;
    assign bus.imem_req_valid = state_q == REQ && count != CW'(DEPTH);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign bus.instr_valid = count != '0;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign pop = bus.instr_valid && bus.instr_ready && !redir;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK    (CLK),
        .resetl (resetl),
        .push   (push),
        .pop    (pop),
        .flush  (redir),
        .wdata  ('{pc: req_pc_q, instr: bus.imem_rsp_data}),
        .rdata  (head),
        .count  (count)
    );
    // next state: normal fetch sequencing, then redirect overrides; an uncollected request forces a discard
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                fetch_pc_d = startpc;
                state_d    = REQ;
            end
            REQ: if (req_fire) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_INCR;
                state_d    = WAIT;
            end
            WAIT: if (bus.imem_rsp_valid) begin
                push    = 1'b1;
                state_d = REQ;
            end
            WAIT_DISCARD: if (bus.imem_rsp_valid) begin
                discard_d = 1'b0;
                state_d   = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (redir) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc;
            if (state_q != WAIT_DISCARD) begin
                discard_d = (state_q == WAIT && !bus.imem_rsp_valid) || req_fire;
                state_d   = discard_d ? WAIT_DISCARD : REQ;
            end
        end
    end
    // FSM, PC and discard registers
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
        end
    end
`ifdef FETCH_STATS_EN
    logic [31:0] flush_cnt_q, flush_cnt_d, stall_cnt_q, stall_cnt_d;
    // saturating redirect and decode-starvation counters
    always_comb begin
        flush_cnt_d = flush_cnt_q + 32'(redir && flush_cnt_q != '1);
        stall_cnt_d = stall_cnt_q + 32'(state_q != IDLE && !bus.instr_valid && stall_cnt_q != '1);
    end
    // counter registers
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign fetch_stats = {flush_cnt_q, stall_cnt_q};
`else
    assign fetch_stats = 64'd0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random-latency memory, PC-sequence reference model and directed fetch scenarios
module tb_instr_fetch_unit;
    import fetch_pkg::*;
    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic [63:0] startpc = '0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] fetch_stats;
    int checks = 0;
    int failures = 0;
    instr_fetch_unit_if bus();
    instr_fetch_unit #(.DEPTH(4)) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .startpc     (startpc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .fetch_stats (fetch_stats)
    );
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    // memory model: one response per accepted request after mem_lat cycles (random 1..4 when 0)
    bit          mem_en = 1'b0;
    bit          mem_rand = 1'b0;
    int          mem_lat = 1;
    bit          pending = 1'b0;
    int          wait_cnt = 0;
    logic [63:0] pend_addr = '0;
    logic [63:0] req_log[$];
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
    end
    always @(negedge CLK) begin
        bus.imem_rsp_valid = 1'b0;
        if (!resetl) begin
            pending = 1'b0;
            bus.imem_req_ready = 1'b0;
        end else begin
            if (pending) begin
                if (wait_cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_f(pend_addr);
                    pending = 1'b0;
                end else wait_cnt--;
            end
            bus.imem_req_ready = mem_en && (!mem_rand || $urandom_range(3) != 0);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                checks++;
                if (pending) begin
                    failures++;
                    $display("FAIL one_outstanding got=2 requests exp=1 addr=%h", bus.imem_req_addr);
                end
                pending   = 1'b1;
                pend_addr = bus.imem_req_addr;
                wait_cnt  = (mem_lat > 0 ? mem_lat : int'($urandom_range(4, 1))) - 1;
                req_log.push_back(bus.imem_req_addr);
            end
        end
    end

    // reference model: decode must see consecutive PCs from the last start/redirect address
    bit          sb_en = 1'b0;
    logic [63:0] exp_pc = '0;
    logic [63:0] seen_pc[$];
    bit          hold = 1'b0;
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    always @(negedge CLK) begin
        #2;
        if (!resetl || !sb_en) hold = 1'b0;
        else begin
            if (hold) begin
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== hold_pc || bus.instr !== hold_instr) begin
                    failures++;
                    $display("FAIL head_stable got=%b/%h/%h exp=1/%h/%h", bus.instr_valid, bus.instr_pc, bus.instr, hold_pc, hold_instr);
                end
            end
            if (bus.instr_valid && bus.instr_ready && !redirect) begin
                checks++;
                if (bus.instr_pc !== exp_pc || bus.instr !== mem_f(exp_pc)) begin
                    failures++;
                    $display("FAIL pop_order got=%h/%h exp=%h/%h", bus.instr_pc, bus.instr, exp_pc, mem_f(exp_pc));
                end
                seen_pc.push_back(bus.instr_pc);
                exp_pc += 64'd4;
            end
            if (redirect) exp_pc = redirect_pc;
            hold       = bus.instr_valid && !bus.instr_ready && !redirect;
            hold_pc    = bus.instr_pc;
            hold_instr = bus.instr;
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] sp);
        step();
        sb_en    = 1'b0;
        resetl   = 1'b0;
        redirect = 1'b0;
        startpc  = sp;
        repeat (2) step();
        req_log.delete();
        seen_pc.delete();
        exp_pc = sp;
        resetl = 1'b1;
        sb_en  = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 3; bus.instr_ready = 1'b0;
        do_reset(64'h1000);
        n = 0;
        while (!(pending && bus.instr_valid) && n < 60) begin step(); n++; end
        checks++;
        if (n >= 60) begin failures++; $display("FAIL reset_setup_timeout got=%0d exp=<60", n); end
        sb_en = 1'b0;
        resetl = 1'b0;
        #1;
        checks += 6;
        if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", bus.instr_valid); end
        if (bus.instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr); end
        if (bus.instr_pc !== 64'd0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", bus.instr_pc); end
        if (bus.imem_req_addr !== 64'd0) begin failures++; $display("FAIL reset_fetch_pc got=%h exp=0", bus.imem_req_addr); end
        if (fetch_stats !== 64'd0) begin failures++; $display("FAIL reset_stats got=%h exp=0", fetch_stats); end
    endtask

    task automatic test_sequential();
        int n;
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 1; bus.instr_ready = 1'b1;
        do_reset(64'h1000);
        n = 0;
        while (!bus.imem_rsp_valid && n < 50) begin step(); n++; end
        step();
        checks++;
        if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL seq_latency got=%b exp=1", bus.instr_valid); end
        n = 0;
        while (seen_pc.size() < 3 && n < 50) begin step(); n++; end
        checks++;
        if (seen_pc.size() < 3) begin failures++; $display("FAIL seq_count got=%0d exp=3", seen_pc.size()); end
        else if (seen_pc[0] !== 64'h1000 || seen_pc[1] !== 64'h1004 || seen_pc[2] !== 64'h1008) begin
            failures++;
            $display("FAIL seq_pcs got=%h,%h,%h exp=1000,1004,1008", seen_pc[0], seen_pc[1], seen_pc[2]);
        end
    endtask

    task automatic test_backpressure();
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 1; bus.instr_ready = 1'b0;
        do_reset(64'h3000);
        repeat (20) step();
        checks += 2;
        if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.instr_valid); end
        if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", bus.imem_req_valid); end
        mem_en = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (seen_pc.size() != 4) begin failures++; $display("FAIL bp_buffered got=%0d exp=4", seen_pc.size()); end
        mem_en = 1'b1;
        repeat (10) step();
        checks++;
        if (seen_pc.size() < 5 || seen_pc[4] !== 64'h3010) begin
            failures++;
            $display("FAIL bp_resume got=%0d entries exp=next pc 3010", seen_pc.size());
        end
    endtask

    task automatic test_redirect_inflight();
        int n;
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 3; bus.instr_ready = 1'b0;
        do_reset(64'h1000);
        n = 0;
        while (!(pending && !bus.imem_rsp_valid && bus.instr_valid) && n < 60) begin step(); n++; end
        checks++;
        if (n >= 60) begin failures++; $display("FAIL rdi_setup_timeout got=%0d exp=<60", n); end
        redirect = 1'b1; redirect_pc = 64'h2000;
        seen_pc.delete();
        step();
        redirect = 1'b0;
        checks += 2;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rdi_flushed got=%b exp=0", bus.instr_valid); end
        if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rdi_discard_noreq got=%b exp=0", bus.imem_req_valid); end
        bus.instr_ready = 1'b1;
        n = 0;
        while (seen_pc.size() < 2 && n < 60) begin step(); n++; end
        checks++;
        if (seen_pc.size() < 2 || seen_pc[0] !== 64'h2000 || seen_pc[1] !== 64'h2004) begin
            failures++;
            $display("FAIL rdi_restart got=%0d entries exp=2000,2004", seen_pc.size());
        end
    endtask

    task automatic test_redirect_rsp();
        int n;
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 2; bus.instr_ready = 1'b1;
        do_reset(64'h1000);
        n = 0;
        while (!bus.imem_rsp_valid && n < 50) begin step(); n++; end
        redirect = 1'b1; redirect_pc = 64'h4000;
        seen_pc.delete();
        step();
        redirect = 1'b0;
        checks += 2;
        if (bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL rdr_no_discard got=%b exp=1", bus.imem_req_valid); end
        if (bus.imem_req_addr !== 64'h4000) begin failures++; $display("FAIL rdr_addr got=%h exp=4000", bus.imem_req_addr); end
        n = 0;
        while (seen_pc.size() < 1 && n < 50) begin step(); n++; end
        checks++;
        if (seen_pc.size() < 1 || seen_pc[0] !== 64'h4000) begin failures++; $display("FAIL rdr_first got=%0d entries exp=4000", seen_pc.size()); end
    endtask

    task automatic test_wrap();
        int n;
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 1; bus.instr_ready = 1'b1;
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        n = 0;
        while ((req_log.size() < 2 || seen_pc.size() < 2) && n < 50) begin step(); n++; end
        checks++;
        if (req_log.size() < 2 || req_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || req_log[1] !== 64'd0) begin
            failures++;
            $display("FAIL wrap_req got=%0d requests exp=FFFFFFFFFFFFFFFC then 0", req_log.size());
        end
        checks++;
        if (seen_pc.size() < 2 || seen_pc[1] !== 64'd0) begin failures++; $display("FAIL wrap_pop got=%0d entries exp=second pc 0", seen_pc.size()); end
    endtask

    task automatic test_stats();
        logic [63:0] exp_stats;
`ifdef FETCH_STATS_EN
        exp_stats = {32'd3, 32'd5};
`else
        exp_stats = 64'd0;
`endif
        mem_en = 1'b0; bus.instr_ready = 1'b1;
        do_reset(64'h0);
        step();
        redirect = 1'b1; redirect_pc = 64'h40;
        repeat (3) step();
        redirect = 1'b0;
        repeat (2) step();
        checks++;
        if (fetch_stats !== exp_stats) begin failures++; $display("FAIL stats got=%h exp=%h", fetch_stats, exp_stats); end
    endtask

    task automatic test_random();
        mem_en = 1'b1; mem_rand = 1'b1; mem_lat = 0;
        do_reset({$urandom, $urandom} & ~64'd3);
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.instr_ready = $urandom_range(9) < 6;
            redirect = $urandom_range(24) == 0;
            if (redirect) redirect_pc = {$urandom, $urandom};
        end
        step();
        redirect = 1'b0;
        checks++;
        if (seen_pc.size() < 100) begin failures++; $display("FAIL random_progress got=%0d exp=>=100", seen_pc.size()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_rsp();
        test_wrap();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
